// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int IQ_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] except;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode. Stops accepting entries
// once a faulting fetch is queued, until a flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_valid,
  input  logic [31:0] push_inst,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_except,
  output logic        push_ready,
  output logic        pop_valid,
  output logic [31:0] pop_inst,
  output logic [31:0] pop_pc,
  output logic [31:0] pop_except,
  input  logic        pop_ready,
  input  logic        flush,
  output logic        hold
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             hold_q;
  logic             full;
  logic             push_fire;
  logic             pop_fire;

  assign full       = (count == CNT_W'(DEPTH));
  assign push_ready = !full && !hold_q;
  assign pop_valid  = (count != '0);
  assign push_fire  = push_valid && push_ready;
  assign pop_fire   = pop_valid && pop_ready;
  assign hold       = hold_q;

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign head_entry = mem[head];
  assign pop_inst   = pop_valid ? head_entry.inst   : '0;
  assign pop_pc     = pop_valid ? head_entry.pc     : '0;
  assign pop_except = pop_valid ? head_entry.except : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      hold_q <= 1'b0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      hold_q <= 1'b0;
    end else begin
      if (push_fire) begin
        tail <= tail + PTR_W'(1);
        if (push_except != '0) begin
          hold_q <= 1'b1;
        end
      end
      if (pop_fire) begin
        head <= head + PTR_W'(1);
      end
      case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_fire && !flush) begin
      mem[tail] <= '{pc: push_pc, inst: push_inst, except: push_except};
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: vector table plus hand-written reset sequences.
module tb_inst_queue;

  localparam logic [31:0] IMASK = 32'h1357_9BDF;
  localparam int NVEC = 28;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic [31:0] push_inst;
  logic [31:0] push_pc;
  logic [31:0] push_except;
  logic        push_ready;
  logic        pop_valid;
  logic [31:0] pop_inst;
  logic [31:0] pop_pc;
  logic [31:0] pop_except;
  logic        pop_ready;
  logic        flush;
  logic        hold;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        pv;
    logic [31:0] ppc;
    logic [31:0] pex;
    logic        pr;
    logic        fl;
    logic        e_val;
    logic [31:0] e_pc;
    logic [31:0] e_ex;
    logic        e_rdy;
    logic        e_hold;
  } vec_t;

  vec_t vecs [NVEC];

  inst_queue #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_inst   (push_inst),
    .push_pc     (push_pc),
    .push_except (push_except),
    .push_ready  (push_ready),
    .pop_valid   (pop_valid),
    .pop_inst    (pop_inst),
    .pop_pc      (pop_pc),
    .pop_except  (pop_except),
    .pop_ready   (pop_ready),
    .flush       (flush),
    .hold        (hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] ppc, input logic [31:0] pex,
                       input logic pr, input logic fl);
    push_valid  = pv;
    push_pc     = ppc;
    push_inst   = ppc ^ IMASK;
    push_except = pex;
    pop_ready   = pr;
    flush       = fl;
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                         input logic [31:0] eex, input logic erdy, input logic eh);
    chk({tag, " pop_valid"},  32'(pop_valid),  32'(ev));
    chk({tag, " pop_pc"},     pop_pc,          epc);
    chk({tag, " pop_inst"},   pop_inst,        ev ? (epc ^ IMASK) : 32'h0);
    chk({tag, " pop_except"}, pop_except,      eex);
    chk({tag, " push_ready"}, 32'(push_ready), 32'(erdy));
    chk({tag, " hold"},       32'(hold),       32'(eh));
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    // Each vector: inputs held for one cycle; expectations are the outputs in that
    // same cycle, i.e. the state produced by the previous vectors.
    //          pv    ppc           pex           pr    fl    val   pc            ex            rdy   hold
    // Scenario 1: three pushes, no pops
    vecs[0]  = '{1'b1, 32'hBFC0_0000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'hBFC0_0004, 32'h0,        1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h0,       1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'hBFC0_0008, 32'h0,        1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h0,       1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'hBFC0_0000, 32'h0,        1'b1, 1'b0};
    // Scenario 5: flush with push and pop in the same cycle
    vecs[4]  = '{1'b1, 32'hDEAD_0000, 32'h0,        1'b1, 1'b1, 1'b1, 32'hBFC0_0000, 32'h0,       1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    // Scenario 2: fill, fifth push refused
    vecs[7]  = '{1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[8]  = '{1'b1, 32'h4,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[9]  = '{1'b1, 32'h8,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'hC,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[11] = '{1'b1, 32'h10,       32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0};
    // Scenario 3: full, pop and push together -> only the pop fires
    vecs[12] = '{1'b1, 32'h14,       32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h4,        32'h0,        1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h8,        32'h0,        1'b1, 1'b0};
    vecs[15] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'hC,        32'h0,        1'b1, 1'b0};
    // Pop while empty is ignored
    vecs[16] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[17] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    // Scenario 4: faulting fetch at pc 0x8 sets hold, queue drains in order
    vecs[18] = '{1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[19] = '{1'b1, 32'h4,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b1, 1'b0};
    vecs[20] = '{1'b1, 32'h8,        32'h0000_4000, 1'b0, 1'b0, 1'b1, 32'h0,       32'h0,        1'b1, 1'b0};
    vecs[21] = '{1'b1, 32'h20,       32'h0,        1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[22] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[23] = '{1'b1, 32'h24,       32'h0,        1'b1, 1'b0, 1'b1, 32'h4,        32'h0,        1'b0, 1'b1};
    vecs[24] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 32'h8,        32'h0000_4000, 1'b0, 1'b1};
    vecs[25] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[26] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b1};
    vecs[27] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0};

    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk_out("reset", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].ppc, vecs[i].pex, vecs[i].pr, vecs[i].fl);
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].e_val, vecs[i].e_pc, vecs[i].e_ex,
              vecs[i].e_rdy, vecs[i].e_hold);
    end

    // Scenario 6: asynchronous reset with two entries queued
    @(negedge clk);
    drive(1'b1, 32'h200, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h204, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk_out("pre_arst", 1'b1, 32'h200, 32'h0, 1'b1, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    chk_out("arst", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h100, 32'h0, 1'b0, 1'b0);
    #1;
    chk_out("post_arst_push", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk_out("post_arst_head", 1'b1, 32'h100, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk_out("post_arst_empty", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, minimum 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-004 push_valid  input  1  fetch stage offers one entry (fetch stage drives it as its own not-stalled signal).
REQ-005 push_inst  input  32  fetched instruction word.
REQ-006 push_pc  input  32  virtual PC of the instruction.
REQ-007 push_except  input  32  fetch exception vector; nonzero marks a faulting fetch.
REQ-008 push_ready  output  1  queue accepts a push this cycle.
REQ-009 pop_valid  output  1  head entry is valid for decode.
REQ-010 pop_inst  output  32  head instruction word.
REQ-011 pop_pc  output  32  head PC.
REQ-012 pop_except  output  32  head exception vector.
REQ-013 pop_ready  input  1  decode consumes the head this cycle (decode not stalled).
REQ-014 flush  input  1  branch redirect or exception; discards all queued entries.
REQ-015 hold  output  1  queue is blocked behind a faulting entry.

Function
REQ-016 Push fires when push_valid && push_ready; pop fires when pop_valid && pop_ready.
REQ-017 push_ready = !full && !hold; push_ready has no combinational dependence on pop_ready or flush.
REQ-018 pop_valid = (count != 0); pop_* come directly from the head entry register, with no bypass from push_*.
REQ-019 Latency: an entry pushed in cycle N is visible on pop_* in cycle N+1 at the earliest.
REQ-020 Pointers: head and tail are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-021 Simultaneous push and pop: count is unchanged, both pointers advance, and FIFO order is preserved.
REQ-022 When full, push_ready=0; a pop in the same cycle does not enable a push in that cycle.
REQ-023 When empty, pop_ready is ignored; pop_inst, pop_pc and pop_except all read 0.
REQ-024 When a push fires with push_except != 0, hold sets in the next cycle; no further pushes are accepted until flush.
REQ-025 While hold=1, already-queued entries, including the faulting one, continue to drain in order.
REQ-026 On flush, in the next cycle: count=0, head=tail=0, hold=0; any push or pop in the flush cycle is discarded.
REQ-027 flush takes priority over push, pop and hold set.
REQ-028 A faulting entry carries push_inst exactly as presented; the queue does not modify any field.

Reset
REQ-029 When rst is low: count=0, head=0, tail=0, hold=0, and all entry storage cleared to 0.
REQ-030 Outputs during and after reset: pop_valid=0, pop_inst=0, pop_pc=0, pop_except=0, hold=0, push_ready=1.
REQ-031 Reset asserted mid-operation discards all entries asynchronously; the first push after rst rises is accepted normally.

Structure
REQ-032 The shared package holds the fetch_entry_t typedef {pc[31:0], inst[31:0], except[31:0]} and the default queue depth constant.
REQ-033 The block is a single module with no sub-module; storage is a fetch_entry_t array indexed by head/tail.

Verification
REQ-034 Scenario 1: after reset, push pc 0xBFC00000/0xBFC00004/0xBFC00008 with pop_ready=0 -> pop_valid=1 from cycle 2, head pc 0xBFC00000, push_ready=1.
REQ-035 Scenario 2: 4 pushes with pop_ready=0 -> push_ready=0 after the fourth push; a 5th push_valid is not accepted; pops return pc 0x0,0x4,0x8,0xC in order.
REQ-036 Scenario 3: queue full, pop_ready=1 and push_valid=1 in the same cycle -> pop fires, push is rejected, count=3 next cycle.
REQ-037 Scenario 4: push an entry with push_except=0x00004000 at pc 0x8 behind pc 0x0 and 0x4 -> hold=1 next cycle; push_ready=0; entries 0x0, 0x4, 0x8 drain with pop_except of the 0x8 entry =0x00004000.
REQ-038 Scenario 5: 3 entries queued, flush=1 with push_valid=1 and pop_ready=1 -> next cycle pop_valid=0, hold=0, push_ready=1; the pushed entry never appears.
REQ-039 Scenario 6: rst driven low between clock edges with 2 entries queued -> pop_valid=0 immediately without a clock edge; after rst rises, a push at pc 0x100 pops as the first entry.
